// File: rtl/booth_seq_multiplier_pkg.sv
// mult_pkg: shared FSM state type and default widths for the Booth multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    localparam int WIDTH_IN_DEF   = 4;
    localparam int WIDTH_PROD_DEF = 2 * WIDTH_IN_DEF;
    localparam int CNT_W_DEF      = $clog2(WIDTH_IN_DEF + 1);
endpackage

// File: rtl/booth_seq_multiplier_booth_step.sv
// booth_step: one radix-2 Booth add/sub on the upper accumulator followed by an arithmetic shift of P.
module booth_step #(
    parameter int W = 4
) (
    input  logic [2*W+1:0] p_i,
    input  logic [W:0]     m_i,
    output logic [2*W+1:0] p_o
);
    logic [W:0] acc;
    assign acc = (p_i[1:0] == 2'b01) ? p_i[2*W+1:W+1] + m_i :
                 (p_i[1:0] == 2'b10) ? p_i[2*W+1:W+1] - m_i : p_i[2*W+1:W+1];
    assign p_o = {acc[W], acc, p_i[W:1]};
endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-2 Booth signed multiplier with valid/ready handshakes.
// Optional MULT_MINMIN_FLAG_EN adds minmin_flag for the most-negative * most-negative case.
module booth_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH_IN   = WIDTH_IN_DEF,
    parameter int WIDTH_PROD = WIDTH_PROD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH_IN-1:0]   a_in,
    input  logic [WIDTH_IN-1:0]   b_in,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef MULT_MINMIN_FLAG_EN
    output logic                  minmin_flag,
`endif
    output logic [WIDTH_PROD-1:0] prod_80
);
    localparam int PW = 2 * WIDTH_IN + 2;
    localparam int CW = $clog2(WIDTH_IN + 1);

    if (WIDTH_PROD != 2 * WIDTH_IN) begin : g_width_chk
        $error("WIDTH_PROD must equal 2*WIDTH_IN");
    end

    state_e                state_q, state_d;
    logic [PW-1:0]         p_q, p_d, p_step;
    logic [WIDTH_IN:0]     m_q, m_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH_PROD-1:0] prod_q, prod_d;

    booth_step #(.W(WIDTH_IN)) u_step (.p_i(p_q), .m_i(m_q), .p_o(p_step));

    // The extra BUSY cycle at cnt==WIDTH_IN moves the finished P into the output register.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: if (in_valid) begin
                m_d     = {a_in[WIDTH_IN-1], a_in};
                p_d     = {{(WIDTH_IN+1){1'b0}}, b_in, 1'b0};
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: if (cnt_q == CW'(WIDTH_IN)) begin
                prod_d  = p_q[WIDTH_PROD:1];
                state_d = DONE;
            end else begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign prod_80   = prod_q;

`ifdef MULT_MINMIN_FLAG_EN
    localparam logic [WIDTH_IN-1:0] MIN_V = {1'b1, {(WIDTH_IN-1){1'b0}}};
    logic mm_q, mm_d, flag_q, flag_d;
    always_comb begin
        mm_d   = (state_q == IDLE && in_valid) ? (a_in == MIN_V && b_in == MIN_V) : mm_q;
        flag_d = (state_q == BUSY && cnt_q == CW'(WIDTH_IN)) ? mm_q :
                 (state_q == DONE && out_ready) ? 1'b0 : flag_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_q   <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            mm_q   <= mm_d;
            flag_q <= flag_d;
        end
    end
    assign minmin_flag = flag_q;
`endif
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: scoreboard bench for the sequential Booth multiplier.
module tb_booth_seq_multiplier;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready;
    logic       in_ready, out_valid;
    logic [3:0] a_in, b_in;
    logic [7:0] prod_80;
`ifdef MULT_MINMIN_FLAG_EN
    logic       minmin_flag;
`endif
    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q[$];

    booth_seq_multiplier dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MULT_MINMIN_FLAG_EN
        .minmin_flag(minmin_flag),
`endif
        .prod_80(prod_80)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
        int ai, bi;
        ai = $signed(a);
        bi = $signed(b);
        return 8'(ai * bi);
    endfunction

    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        a_in = a;
        b_in = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cyc = k;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod_80 !== 8'h00)
            $display("FAIL reset: in_ready=%b out_valid=%b prod=%h want 1 0 00", in_ready, out_valid, prod_80);
        else passed++;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [3:0] ta [6] = '{4'h3, 4'h8, 4'hD, 4'h0, 4'h8, 4'h7};
        logic [3:0] tb [6] = '{4'h2, 4'h7, 4'h5, 4'hB, 4'h8, 4'h7};
        logic [7:0] e;
        int cyc;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb[i]);
            exp_q.push_back(model(ta[i], tb[i]));
            wait_valid(cyc, ok);
            e = exp_q.pop_front();
            total++;
            if (!ok || cyc != 5) $display("FAIL latency[%0d]: got %0d want 5", i, cyc);
            else passed++;
            total++;
            if (prod_80 !== e) $display("FAIL prod[%0d]: %h*%h got %h want %h", i, ta[i], tb[i], prod_80, e);
            else passed++;
`ifdef MULT_MINMIN_FLAG_EN
            total++;
            if (minmin_flag !== (ta[i] == 4'h8 && tb[i] == 4'h8))
                $display("FAIL minmin[%0d]: got %b want %b", i, minmin_flag, (ta[i] == 4'h8 && tb[i] == 4'h8));
            else passed++;
`endif
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL release[%0d]: out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
            else passed++;
        end
        total++;
        if (model(4'h8, 4'h8) !== 8'h40 || model(4'h8, 4'h7) !== 8'hC8)
            $display("FAIL model: minmin=%h want 40, -8*7=%h want c8", model(4'h8, 4'h8), model(4'h8, 4'h7));
        else passed++;
    endtask

    task automatic test_backpressure;
        logic [7:0] e;
        int cyc;
        bit ok;
        int bad = 0;
        start_op(4'h5, 4'hA);
        exp_q.push_back(8'hE2);
        wait_valid(cyc, ok);
        e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a_in = 4'($urandom);
            b_in = 4'($urandom);
            @(posedge clk);
            #1;
            if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || prod_80 !== e) bad++;
        end
        in_valid = 1'b0;
        total++;
        if (bad != 0) $display("FAIL hold: %0d unstable cycles, prod=%h want %h", bad, prod_80, e);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_ignored: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_reset_midop;
        logic [7:0] e;
        int cyc;
        bit ok;
        int extra = 0;
        start_op(4'h7, 4'h7);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || prod_80 !== 8'h00)
            $display("FAIL async_rst: out_valid=%b in_ready=%b prod=%h want 0 1 00", out_valid, in_ready, prod_80);
        else passed++;
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        start_op(4'h2, 4'hF);
        exp_q.push_back(model(4'h2, 4'hF));
        wait_valid(cyc, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || prod_80 !== e || e !== 8'hFE) $display("FAIL post_rst: got %h want fe", prod_80);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        total++;
        if (extra != 0) $display("FAIL stale_result: %0d extra valid cycles want 0", extra);
        else passed++;
    endtask

    task automatic test_sweep;
        logic [7:0] e;
        int cyc;
        bit ok;
        int got = 0;
        int errs = 0;
        bit taken;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(4'(a), 4'(b));
                exp_q.push_back(model(4'(a), 4'(b)));
                wait_valid(cyc, ok);
                if (!ok) begin
                    errs++;
                    continue;
                end
                taken = 1'b0;
                for (int k = 0; k < 8 && !taken; k++) begin
                    out_ready = (k == 7) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (out_ready) begin
                        taken = 1'b1;
                        got++;
                        e = exp_q.pop_front();
                        if (prod_80 !== e) begin
                            errs++;
                            if (errs < 5) $display("FAIL sweep %0d*%0d: got %h want %h", a, b, prod_80, e);
                        end
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                if (out_valid !== 1'b0) errs++;
            end
        end
        total++;
        if (errs != 0) $display("FAIL sweep_errors: got %0d want 0", errs);
        else passed++;
        total++;
        if (got != 256 || exp_q.size() != 0)
            $display("FAIL sweep_count: got %0d products, %0d pending, want 256 and 0", got, exp_q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
